eth_pcs_rx_block_sync: RTL and testbench

RX block synchronizer for the 10GBASE-R PCS (IEEE 802.3 cl. 49.2.13.2.2 lock FSM). It sits directly downstream of the RX gearbox, where it tests each 2-bit sync header. It asserts block lock after SH_TH consecutive valid headers and requests a one-bit gearbox slip when alignment is bad. Its lock output qualifies blocks fed to the descrambler and decoder.

---
 rtl/eth_pcs_rx_block_sync_pkg.sv | 25 ++
 rtl/eth_pcs_rx_block_sync_sh_window.sv | 54 +++++
 rtl/eth_pcs_rx_block_sync.sv | 104 ++++++++++
 tb/tb_eth_pcs_rx_block_sync.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/eth_pcs_rx_block_sync_pkg.sv
// Shared 10GBASE-R PCS constants, sync-header codes and block-sync state encoding.
// Pure declarations: no latency, no flow control.
package eth_pcs_params;

  localparam int W_SYNC        = 2;
  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b10;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b01;

  localparam int SH_TH         = 64;
  localparam int SH_INVAL_TH   = 16;
  localparam int W_SH_TH       = $clog2(SH_TH);
  localparam int W_SH_INVAL_TH = $clog2(SH_INVAL_TH);
  localparam int SLIP_WAIT_DEF = 2;

  typedef enum logic [1:0] {
    BS_SEARCH,
    BS_LOCKED,
    BS_SLIP_WAIT
  } blk_sync_state_t;

  function automatic logic sh_is_valid(input logic [W_SYNC-1:0] sh);
    return (sh == SYNC_DATA) || (sh == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_pcs_rx_block_sync_sh_window.sv
// Header test window: counts strobes and invalid headers; terminal flags are combinational on the qualifying strobe.
// Counters update one cycle after the strobe; no backpressure, acts only when i_strobe=1.
module eth_pcs_sh_window
  import eth_pcs_params::*;
#(
  parameter int SH_TH       = eth_pcs_params::SH_TH,
  parameter int SH_INVAL_TH = eth_pcs_params::SH_INVAL_TH
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_strobe,
  input  logic i_invalid,
  output logic o_win_end,
  output logic o_inv_th
);

  localparam int W_SH  = (SH_TH > 1) ? $clog2(SH_TH) : 1;
  localparam int W_INV = (SH_INVAL_TH > 1) ? $clog2(SH_INVAL_TH) : 1;
  localparam logic [W_SH-1:0]  SH_LAST  = W_SH'(SH_TH - 1);
  localparam logic [W_INV-1:0] INV_LAST = W_INV'(SH_INVAL_TH - 1);

  logic [W_SH-1:0]  sh_cnt_q, sh_cnt_d;
  logic [W_INV-1:0] inv_cnt_q, inv_cnt_d;

  assign o_win_end = i_strobe && (sh_cnt_q == SH_LAST);
  assign o_inv_th  = i_strobe && i_invalid && (inv_cnt_q == INV_LAST);

  // Terminal counts are decoded, never wrapped: window end clears both counters.
  always_comb begin
    sh_cnt_d  = sh_cnt_q;
    inv_cnt_d = inv_cnt_q;
    if (i_clr || o_win_end) begin
      sh_cnt_d  = '0;
      inv_cnt_d = '0;
    end else if (i_strobe) begin
      sh_cnt_d = sh_cnt_q + W_SH'(1);
      if (i_invalid) begin
        inv_cnt_d = inv_cnt_q + W_INV'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_cnt_q  <= '0;
      inv_cnt_q <= '0;
    end else begin
      sh_cnt_q  <= sh_cnt_d;
      inv_cnt_q <= inv_cnt_d;
    end
  end

endmodule

// File: rtl/eth_pcs_rx_block_sync.sv
// 10GBASE-R RX block lock FSM: tests sync headers, raises lock, requests one-bit gearbox slips.
// Strobe at cycle N shows on registered outputs at N+1; no backpressure, acts only on i_sh_valid.
module eth_pcs_rx_block_sync
  import eth_pcs_params::*;
#(
  parameter int SH_TH       = eth_pcs_params::SH_TH,
  parameter int SH_INVAL_TH = eth_pcs_params::SH_INVAL_TH,
  parameter int SLIP_WAIT   = SLIP_WAIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sh_valid,
  input  logic [W_SYNC-1:0] i_sh,
  output logic              o_slip,
  output logic              o_block_lock,
  output logic              o_blk_valid
);

  localparam logic [2:0] WAIT_LOAD = 3'(SLIP_WAIT - 1);

  blk_sync_state_t state_q;
  logic            lock_q;
  logic            slip_q;
  logic            blk_valid_q;
  logic [2:0]      wait_cnt_q;

  logic hdr_ok;
  logic win_strobe;
  logic win_clr;
  logic win_end;
  logic inv_th;

  assign hdr_ok     = sh_is_valid(i_sh);
  assign win_strobe = i_sh_valid && (state_q != BS_SLIP_WAIT);
  // Clear the window on every exit to SLIP_WAIT; window end clears itself.
  assign win_clr    = i_sh_valid &&
                      (((state_q == BS_SEARCH) && !hdr_ok) ||
                       ((state_q == BS_LOCKED) && inv_th));

  eth_pcs_sh_window #(
    .SH_TH       (SH_TH),
    .SH_INVAL_TH (SH_INVAL_TH)
  ) u_sh_window (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (win_clr),
    .i_strobe  (win_strobe),
    .i_invalid (!hdr_ok),
    .o_win_end (win_end),
    .o_inv_th  (inv_th)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= BS_SEARCH;
      lock_q      <= 1'b0;
      slip_q      <= 1'b0;
      blk_valid_q <= 1'b0;
      wait_cnt_q  <= 3'd0;
    end else begin
      slip_q      <= 1'b0;
      // Qualified with the lock state seen before this strobe.
      blk_valid_q <= i_sh_valid && lock_q && hdr_ok;
      if (i_sh_valid) begin
        case (state_q)
          BS_SEARCH: begin
            if (!hdr_ok) begin
              slip_q     <= 1'b1;
              wait_cnt_q <= WAIT_LOAD;
              state_q    <= BS_SLIP_WAIT;
            end else if (win_end) begin
              lock_q  <= 1'b1;
              state_q <= BS_LOCKED;
            end
          end
          BS_LOCKED: begin
            if (inv_th) begin
              lock_q     <= 1'b0;
              slip_q     <= 1'b1;
              wait_cnt_q <= WAIT_LOAD;
              state_q    <= BS_SLIP_WAIT;
            end
          end
          BS_SLIP_WAIT: begin
            if (wait_cnt_q == 3'd0) begin
              state_q <= BS_SEARCH;
            end else begin
              wait_cnt_q <= wait_cnt_q - 3'd1;
            end
          end
          default: begin
            lock_q  <= 1'b0;
            state_q <= BS_SEARCH;
          end
        endcase
      end
    end
  end

  assign o_slip       = slip_q;
  assign o_block_lock = lock_q;
  assign o_blk_valid  = blk_valid_q;

endmodule

// File: tb/tb_eth_pcs_rx_block_sync.sv
// Directed bench for the block synchronizer: table of strobe runs plus hand-written reset sequences.
module tb_eth_pcs_rx_block_sync;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_sh_valid = 1'b0;
  logic [1:0] i_sh = 2'b00;
  logic       o_slip;
  logic       o_block_lock;
  logic       o_blk_valid;

  int errors = 0;
  int checks = 0;
  int slip_seen = 0;
  int slip_consec = 0;
  logic slip_prev = 1'b0;

  typedef struct {
    int   n;
    int   inv_mod;
    int   gap;
    logic exp_lock;
    logic exp_slip;
    logic exp_bv;
    int   exp_slips;
  } step_t;

  step_t tbl [16];

  eth_pcs_rx_block_sync dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_sh_valid   (i_sh_valid),
    .i_sh         (i_sh),
    .o_slip       (o_slip),
    .o_block_lock (o_block_lock),
    .o_blk_valid  (o_blk_valid)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_slip) begin
      slip_seen++;
      if (slip_prev) slip_consec++;
    end
    slip_prev = o_slip;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] hdr(input int i, input int inv_mod);
    if (inv_mod != 0 && (i % inv_mod) == 0) return (i % 2 != 0) ? 2'b11 : 2'b00;
    return (i % 2 != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic do_strobe(input logic [1:0] sh, input int gap,
                           output logic s, output logic l, output logic b);
    i_sh_valid = 1'b1;
    i_sh       = sh;
    @(posedge i_clk);
    #1;
    s = o_slip;
    l = o_block_lock;
    b = o_blk_valid;
    i_sh_valid = 1'b0;
    i_sh       = 2'b00;
    repeat (gap) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
  endtask

  logic s, l, b;

  initial begin
    // n, inv_mod, gap, lock, slip, blk_valid, slips during run
    tbl = '{
      '{63, 0, 0, 1'b0, 1'b0, 1'b0, 0},   // one short of lock
      '{ 1, 0, 0, 1'b1, 1'b0, 1'b0, 0},   // 64th valid: lock, not flagged
      '{ 1, 0, 0, 1'b1, 1'b0, 1'b1, 0},   // window strobe 1
      '{60, 4, 0, 1'b1, 1'b0, 1'b0, 0},   // 15 invalids, strobes 2..61
      '{ 3, 0, 0, 1'b1, 1'b0, 1'b1, 0},   // strobes 62..64: window end
      '{64, 4, 0, 1'b0, 1'b1, 1'b0, 1},   // 16th invalid on 64th strobe
      '{ 2, 1, 0, 1'b0, 1'b0, 1'b0, 0},   // ignored in SLIP_WAIT
      '{ 9, 0, 0, 1'b0, 1'b0, 1'b0, 0},
      '{ 1, 1, 0, 1'b0, 1'b1, 1'b0, 1},   // 10th header 2'b11
      '{ 2, 1, 0, 1'b0, 1'b0, 1'b0, 0},   // ignored
      '{63, 0, 2, 1'b0, 1'b0, 1'b0, 0},   // strobe every 3rd cycle
      '{ 1, 0, 2, 1'b1, 1'b0, 1'b0, 0},
      '{ 1, 0, 2, 1'b1, 1'b0, 1'b1, 0},
      '{10, 0, 2, 1'b1, 1'b0, 1'b1, 0},   // window strobe 11
      '{15, 1, 0, 1'b1, 1'b0, 1'b0, 0},   // 15 invalids mid-window
      '{ 1, 1, 0, 1'b0, 1'b1, 1'b0, 1}    // 16th invalid drops lock
    };

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_slip", o_slip, 0);
    chk("rst_lock", o_block_lock, 0);
    chk("rst_blk_valid", o_blk_valid, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;

    for (int r = 0; r < 16; r++) begin
      slip_seen = 0;
      for (int i = 1; i <= tbl[r].n; i++) do_strobe(hdr(i, tbl[r].inv_mod), tbl[r].gap, s, l, b);
      @(negedge i_clk);
      #1;
      chk($sformatf("row%0d_lock", r), l, tbl[r].exp_lock);
      chk($sformatf("row%0d_slip", r), s, tbl[r].exp_slip);
      chk($sformatf("row%0d_blk_valid", r), b, tbl[r].exp_bv);
      chk($sformatf("row%0d_slip_count", r), slip_seen, tbl[r].exp_slips);
    end

    // Leave SLIP_WAIT, relock, then reset asynchronously mid-window.
    do_strobe(2'b00, 0, s, l, b);
    do_strobe(2'b00, 0, s, l, b);
    for (int i = 1; i <= 64; i++) begin
      do_strobe(hdr(i, 0), 0, s, l, b);
      if (i == 63) chk("relock_63", l, 0);
    end
    chk("relock_64", l, 1);
    do_strobe(2'b10, 0, s, l, b);
    chk("bv_on_strobe", b, 1);
    @(posedge i_clk);
    #1;
    chk("bv_idle", o_blk_valid, 0);
    for (int i = 1; i <= 4; i++) do_strobe(2'b01, 0, s, l, b);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_lock", o_block_lock, 0);
    chk("async_rst_bv", o_blk_valid, 0);
    apply_reset();
    for (int i = 1; i <= 64; i++) begin
      do_strobe(hdr(i, 0), 0, s, l, b);
      if (i == 63) chk("post_rst_63", l, 0);
    end
    chk("post_rst_64", l, 1);

    // Reset while a slip pulse is live and SLIP_WAIT has just been entered.
    apply_reset();
    do_strobe(2'b11, 0, s, l, b);
    chk("search_slip", s, 1);
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_slip", o_slip, 0);
    apply_reset();
    slip_seen = 0;
    for (int i = 1; i <= 64; i++) begin
      do_strobe(hdr(i, 0), 0, s, l, b);
      if (i == 63) chk("slipwait_rst_63", l, 0);
    end
    chk("slipwait_rst_64", l, 1);
    @(negedge i_clk);
    #1;
    chk("slipwait_rst_slips", slip_seen, 0);
    chk("slip_consecutive", slip_consec, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
